// File: rtl/sr_flag_bank.sv
// Clocked bank of SR flag cells with edge pulses, per-channel conflict flags
// and a saturating count of edges on which any channel conflicted.
module sr_flag_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 0,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] notq,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] both_val;
    logic [WIDTH-1:0] both;

    // Value a channel takes when s and r are both asserted; illegal MODEs hold.
    always_comb begin
        case (MODE)
            0:       both_val = '0;
            1:       both_val = '1;
            2:       both_val = ~q_q;
            default: both_val = q_q;
        endcase
    end

    always_comb begin
        both       = s & r;
        q_d        = q_q;
        rise_d     = '0;
        fall_d     = '0;
        conflict_d = '0;
        cnt_d      = cnt_q;
        if (en) begin
            q_d        = (s & ~r) | (~s & ~r & q_q) | (both & both_val);
            rise_d     = ~q_q & q_d;
            fall_d     = q_q & ~q_d;
            conflict_d = both;
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (en && (|both) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q        <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            conflict_q <= '0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q            = q_q;
    assign notq         = ~q_q;
    assign rise         = rise_q;
    assign fall         = fall_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Scoreboard bench: four 4-channel banks (MODE 0..3, 2-bit counter) share stimulus.
module tb_sr_flag_bank;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          clr_cnt;
    logic [W-1:0]  s;
    logic [W-1:0]  r;

    logic [W-1:0]  q_o    [4];
    logic [W-1:0]  notq_o [4];
    logic [W-1:0]  rise_o [4];
    logic [W-1:0]  fall_o [4];
    logic [W-1:0]  conf_o [4];
    logic [CW-1:0] cnt_o  [4];

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_flag_bank #(.WIDTH(W), .MODE(m), .CNT_W(CW)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en),
            .s            (s),
            .r            (r),
            .clr_cnt      (clr_cnt),
            .q            (q_o[m]),
            .notq         (notq_o[m]),
            .rise         (rise_o[m]),
            .fall         (fall_o[m]),
            .conflict     (conf_o[m]),
            .conflict_cnt (cnt_o[m])
        );
    end

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  rise;
        logic [W-1:0]  fall;
        logic [W-1:0]  conf;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    logic [W-1:0]  mq   [4];
    logic [CW-1:0] mcnt [4];
    int            n_cmp = 0;
    int            n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int unsigned m = 0; m < 4; m++) begin
            mq[m]   = '0;
            mcnt[m] = '0;
        end
    endtask

    task automatic check_reset(input string tag);
        for (int unsigned m = 0; m < 4; m++) begin
            check($sformatf("%s q m%0d", tag, m),    q_o[m],    32'h0);
            check($sformatf("%s notq m%0d", tag, m), notq_o[m], 32'hF);
            check($sformatf("%s rise m%0d", tag, m), rise_o[m], 32'h0);
            check($sformatf("%s fall m%0d", tag, m), fall_o[m], 32'h0);
            check($sformatf("%s conf m%0d", tag, m), conf_o[m], 32'h0);
            check($sformatf("%s cnt m%0d", tag, m),  cnt_o[m],  32'h0);
        end
    endtask

    // Drive one edge's inputs, predict every bank's outputs, then compare after the edge.
    task automatic step(input string tag, input logic e, input logic [W-1:0] sv,
                        input logic [W-1:0] rv, input logic clr);
        exp_t          x;
        logic [W-1:0]  nq;
        logic          bit_n;
        en      = e;
        s       = sv;
        r       = rv;
        clr_cnt = clr;
        for (int unsigned m = 0; m < 4; m++) begin
            for (int unsigned i = 0; i < W; i++) begin
                bit_n = mq[m][i];
                if (e) begin
                    if (sv[i] && !rv[i])      bit_n = 1'b1;
                    else if (!sv[i] && rv[i]) bit_n = 1'b0;
                    else if (sv[i] && rv[i]) begin
                        if (m == 0)      bit_n = 1'b0;
                        else if (m == 1) bit_n = 1'b1;
                        else if (m == 2) bit_n = ~mq[m][i];
                    end
                end
                nq[i] = bit_n;
            end
            x.rise = e ? (~mq[m] & nq) : '0;
            x.fall = e ? (mq[m] & ~nq) : '0;
            x.conf = e ? (sv & rv) : '0;
            if (clr)                                   mcnt[m] = '0;
            else if (e && ((sv & rv) != '0) && mcnt[m] != 2'd3) mcnt[m] = mcnt[m] + 2'd1;
            mq[m] = nq;
            x.q   = nq;
            x.cnt = mcnt[m];
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        for (int unsigned m = 0; m < 4; m++) begin
            if (sb.size() == 0) begin
                check($sformatf("%s sb_empty m%0d", tag, m), 32'h1, 32'h0);
            end else begin
                x  = sb.pop_front();
                nq = ~x.q;
                check($sformatf("%s q m%0d", tag, m),    q_o[m],    x.q);
                check($sformatf("%s notq m%0d", tag, m), notq_o[m], nq);
                check($sformatf("%s rise m%0d", tag, m), rise_o[m], x.rise);
                check($sformatf("%s fall m%0d", tag, m), fall_o[m], x.fall);
                check($sformatf("%s conf m%0d", tag, m), conf_o[m], x.conf);
                check($sformatf("%s cnt m%0d", tag, m),  cnt_o[m],  x.cnt);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        clr_cnt = 1'b0;
        s       = '0;
        r       = '0;
        model_reset();
        #3;
        check_reset("reset_no_clk");
        @(negedge clk);
        rst_n = 1'b1;

        step("set_0101",  1'b1, 4'b0101, 4'b0000, 1'b0);
        check("lit q after set", q_o[0], 32'h5);
        check("lit rise after set", rise_o[3], 32'h5);
        step("reset_bit0", 1'b1, 4'b0000, 4'b0001, 1'b0);
        check("lit fall bit0", fall_o[1], 32'h1);
        step("hold",      1'b1, 4'b0000, 4'b0000, 1'b0);
        step("load_0011", 1'b1, 4'b0011, 4'b1100, 1'b0);
        step("mode_sweep", 1'b1, 4'b1111, 4'b1111, 1'b0);
        check("lit sweep m0", q_o[0], 32'h0);
        check("lit sweep m1", q_o[1], 32'hF);
        check("lit sweep m2", q_o[2], 32'hC);
        check("lit sweep m3", q_o[3], 32'h3);
        check("lit sweep cnt", cnt_o[3], 32'h1);
        step("en_off",    1'b0, 4'b1111, 4'b0000, 1'b0);
        step("en_on",     1'b1, 4'b1111, 4'b0000, 1'b0);

        step("cnt_clr",   1'b1, 4'b0000, 4'b0000, 1'b1);
        for (int k = 0; k < 5; k++) step($sformatf("cnt_sat%0d", k), 1'b1, 4'b1111, 4'b1111, 1'b0);
        check("lit cnt saturated", cnt_o[0], 32'h3);
        step("clr_vs_conf", 1'b1, 4'b1111, 4'b1111, 1'b1);
        check("lit cnt clr wins", cnt_o[2], 32'h0);

        step("toggle_a", 1'b1, 4'b1111, 4'b1111, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset("reset_mid");
        #1;
        rst_n = 1'b1;
        step("after_reset", 1'b1, 4'b1111, 4'b1111, 1'b0);
        check("lit toggle q", q_o[2], 32'hF);
        check("lit toggle rise", rise_o[2], 32'hF);
        step("toggle_b", 1'b1, 4'b1111, 4'b1111, 1'b0);

        for (int k = 0; k < 40; k++) begin
            step($sformatf("rnd%0d", k), ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr_flag_bank.md
# sr_flag_bank

Parametrised, clocked bank of SR flag cells: the synchronous, multi-channel successor to the single-bit SR latch. Each of WIDTH channels holds one flag bit driven by per-channel set/reset inputs. A MODE parameter resolves the s=r=1 case. The bank adds edge pulses, per-channel conflict flags and a saturating conflict counter. It is the status/flag store for control blocks that today instantiate loose SR latches.

## Interface
- WIDTH, 8, number of independent flag channels (≥1)
- MODE, 0, s=r=1 resolution: 0 reset-dominant, 1 set-dominant, 2 toggle (JK), 3 hold
- CNT_W, 4, width of conflict counter (≥1)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  update enable; 0 freezes the bank
- s  in  WIDTH  per-channel set
- r  in  WIDTH  per-channel reset
- clr_cnt  in  1  synchronous clear of conflict_cnt
- q  out  WIDTH  flag state (registered)
- notq  out  WIDTH  always ~q (combinational from q)
- rise  out  WIDTH  1-cycle pulse, channel q went 0→1
- fall  out  WIDTH  1-cycle pulse, channel q went 1→0
- conflict  out  WIDTH  registered: channel saw s=r=1 on last enabled edge
- conflict_cnt  out  CNT_W  saturating count of enabled edges with any conflict

## Operation
- Per channel i, at rising clk with en=1, q_next[i]:
  - s=0 r=0 → q[i] (hold)
  - s=1 r=0 → 1
  - s=0 r=1 → 0
  - s=1 r=1 → MODE 0: 0; MODE 1: 1; MODE 2: ~q[i]; MODE 3: q[i]
- Channels are fully independent; no cross-channel interaction except conflict_cnt.
- rise[i] <= en & ~q[i] & q_next[i]; fall[i] <= en & q[i] & ~q_next[i].
- conflict[i] <= en & s[i] & r[i]. Set in every MODE, including MODE 3.
- conflict_cnt, evaluated each edge in priority order:
  - clr_cnt=1 → 0, regardless of en or conflicts
  - else en=1 and |(s&r) → +1, saturating at 2^CNT_W−1
  - else hold
  - Increment is at most 1 per edge, however many channels conflict.
- en=0 on an edge:
  - q and conflict_cnt hold (clr_cnt still applies)
  - rise, fall, conflict all go to 0
- Unused MODE values (>3) are illegal; implementation treats them as MODE 3.

## Timing
- rst_n=0, asynchronous and immediate (no clk needed): q=0, notq=all ones, rise=0, fall=0, conflict=0, conflict_cnt=0.
- Reset asserted mid-operation overrides any in-flight update. Pulses in progress are cut off.
- First rising edge after rst_n rises behaves as a normal edge. No extra dead cycle.
- Latency: inputs sampled on edge N; q, rise, fall, conflict and conflict_cnt reflect them right after edge N. One cycle in total.
- rise/fall are high exactly for the first cycle in which the new q is visible, then drop unless q changes again.
- MODE 2 with s=r=1 held: q toggles every enabled edge. rise and fall alternate each cycle.
- notq tracks q within the same cycle. No register, no skew beyond combinational delay.
- Saturation: at 2^CNT_W−1, further conflicts leave the count unchanged. Simultaneous clr_cnt and conflict gives 0.

## Test plan
- Reset, WIDTH=4: rst_n=0 between edges → q=0000, notq=1111, conflict_cnt=0 with no clk edge. Release, edge with s=0101, r=0000, en=1 → q=0101, rise=0101 for one cycle.
- Hold/reset path: from q=0101, edge with s=0000, r=0001 → q=0100, fall=0001. Next edge s=r=0 → q=0100, rise=fall=0.
- MODE sweep: q=0011, s=r=1111 for one edge. MODE 0 → 0000; MODE 1 → 1111; MODE 2 → 1100; MODE 3 → 0011. Each case gives conflict=1111, conflict_cnt=1.
- Enable gating: en=0 with s=1111, r=0000 → q unchanged, rise=0, conflict=0, cnt unchanged. Next edge with en=1 → q=1111.
- Counter, CNT_W=2: 5 consecutive conflicting edges → cnt 1,2,3,3,3. Then clr_cnt=1 with a conflict on the same edge → cnt=0.
- Async reset mid-toggle, MODE 2, s=r=1 held: assert rst_n=0 mid-cycle → all outputs at reset values at once. Release → first edge gives q=1111, rise=1111.
